// File: rtl/mem_access_unit.sv
// Load/store bridge: turns one byte/half/word core request into one or two
// word-aligned RAM bus beats with byte strobes, then returns extended load data.
package mem_access_pkg;
   localparam logic [31:0] RAM_BASE_ADDR = 32'h0000_1000;
   localparam logic [31:0] RAM_END_ADDR  = 32'h0000_2000;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BEAT0,
      S_BEAT1,
      S_RESP
   } state_e;
endpackage

module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = RAM_BASE_ADDR,
   parameter logic [31:0] END_ADDR  = RAM_END_ADDR
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] addr,
   output logic [31:0] wdata,
   output logic        re,
   output logic        we,
   output logic [3:0]  wstrb,
   input  logic [31:0] rdata
);

   state_e      state_q, state_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [7:0]  mask_q, mask_d;
   logic        err_q, err_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] hi_q, hi_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        resp_err_q, resp_err_d;

   // Request decode, evaluated on the live request inputs for use at accept.
   logic [2:0]  req_nbytes;
   logic [7:0]  req_mask;
   logic [32:0] req_last_byte;
   logic        req_err;

   always_comb begin
      case (req_size)
         2'b00:   req_nbytes = 3'd1;
         2'b01:   req_nbytes = 3'd2;
         default: req_nbytes = 3'd4;
      endcase
      req_mask      = ((8'd1 << req_nbytes) - 8'd1) << req_addr[1:0];
      req_last_byte = {1'b0, req_addr} + {30'd0, req_nbytes} - 33'd1;
      req_err       = (req_size == 2'b11) || (req_addr < BASE_ADDR) ||
                      (req_last_byte >= {1'b0, END_ADDR});
   end

   logic [63:0] assembled;
   logic [31:0] load_word;
   logic [31:0] load_ext;

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d = state_q;
      we_d    = we_q;
      size_d  = size_q;
      uns_d   = uns_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      mask_d  = mask_q;
      err_d   = err_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      addr    = 32'd0;
      wdata   = 32'd0;
      re      = 1'b0;
      we      = 1'b0;
      wstrb   = 4'd0;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               size_d  = req_size;
               uns_d   = req_unsigned;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               mask_d  = req_mask;
               err_d   = req_err;
               state_d = req_err ? S_RESP : S_BEAT0;
            end
         end
         S_BEAT0: begin
            addr  = {addr_q[31:2], 2'b00};
            re    = !we_q;
            we    = we_q;
            wstrb = mask_q[3:0];
            wdata = wdata_q << {addr_q[1:0], 3'b000};
            if (!we_q) lo_d = rdata;
            state_d = (|mask_q[7:4]) ? S_BEAT1 : S_RESP;
         end
         S_BEAT1: begin
            addr  = {addr_q[31:2], 2'b00} + 32'd4;
            re    = !we_q;
            we    = we_q;
            wstrb = mask_q[7:4];
            wdata = wdata_q >> (6'd32 - {1'b0, addr_q[1:0], 3'b000});
            if (!we_q) hi_d = rdata;
            state_d = S_RESP;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Response is registered on the edge that enters RESP, so it is built
      // from the buffer values being captured on that same edge.
      assembled = {hi_d, lo_d} >> {addr_d[1:0], 3'b000};
      load_word = assembled[31:0];
      case (size_d)
         2'b00:   load_ext = uns_d ? {24'd0, load_word[7:0]}
                                   : {{24{load_word[7]}}, load_word[7:0]};
         2'b01:   load_ext = uns_d ? {16'd0, load_word[15:0]}
                                   : {{16{load_word[15]}}, load_word[15:0]};
         default: load_ext = load_word;
      endcase

      resp_valid_d = (state_d == S_RESP);
      resp_err_d   = resp_valid_d && err_d;
      resp_rdata_d = (resp_valid_d && !err_d && !we_d) ? load_ext : 32'd0;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         we_q         <= 1'b0;
         size_q       <= 2'b00;
         uns_q        <= 1'b0;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         mask_q       <= 8'd0;
         err_q        <= 1'b0;
         lo_q         <= 32'd0;
         hi_q         <= 32'd0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'd0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         mask_q       <= mask_d;
         err_q        <= err_d;
         lo_q         <= lo_d;
         hi_q         <= hi_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign req_ready  = (state_q == S_IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a word RAM model and a bus beat log.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        re;
   logic        we;
   logic [3:0]  wstrb;
   logic [31:0] rdata;

   int total = 0;
   int bad   = 0;
   int both_cnt = 0;

   mem_access_unit dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .addr(addr), .wdata(wdata), .re(re), .we(we),
      .wstrb(wstrb), .rdata(rdata)
   );

   always #5 clk = ~clk;

   // RAM covering 0x1000..0x1FFF, async read, strobed write on posedge.
   logic [31:0] mem [0:1023];
   assign rdata = re ? mem[addr[11:2]] : 32'd0;

   always @(posedge clk) begin
      if (we) begin
         if (wstrb[0]) mem[addr[11:2]][7:0]   <= wdata[7:0];
         if (wstrb[1]) mem[addr[11:2]][15:8]  <= wdata[15:8];
         if (wstrb[2]) mem[addr[11:2]][23:16] <= wdata[23:16];
         if (wstrb[3]) mem[addr[11:2]][31:24] <= wdata[31:24];
      end
   end

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      logic        r;
      logic        w;
   } beat_t;
   beat_t beats[$];

   always @(posedge clk) begin
      if (re || we) beats.push_back('{addr, wdata, wstrb, re, we});
      if (re && we) both_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_beat(input string tag, input int idx, input logic [31:0] a,
                             input logic [3:0] s, input logic [31:0] d,
                             input logic r, input logic w);
      if (beats.size() > idx) begin
         check({tag, " addr"},  beats[idx].a, a);
         check({tag, " wstrb"}, {28'd0, beats[idx].s}, {28'd0, s});
         check({tag, " wdata"}, beats[idx].d, d);
         check({tag, " re/we"}, {30'd0, beats[idx].r, beats[idx].w}, {30'd0, r, w});
      end else begin
         check({tag, " present"}, 32'(beats.size()), 32'(idx + 1));
      end
   endtask

   // Issues one request from IDLE and waits (bounded) for the response pulse.
   task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] rd, output logic er);
      bit got = 0;
      @(negedge clk);
      beats.delete();
      req_valid = 1'b1; req_we = w; req_size = sz; req_unsigned = u;
      req_addr = a; req_wdata = d;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
      req_we = ~w; req_size = 2'b11;
      lat = 0; rd = 32'hx; er = 1'bx;
      for (int k = 1; k <= 10 && !got; k++) begin
         @(negedge clk);
         if (resp_valid) begin
            got = 1; lat = k; rd = resp_rdata; er = resp_err;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      logic [31:0] rd;
      logic        er;
      int          stray;

      for (int i = 0; i < 1024; i++) mem[i] = 32'd0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst bus", {addr | wdata}, 32'd0);
      check("rst ctl", {27'd0, re, we, wstrb[2:0]} | {28'd0, wstrb}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst ready", {31'd0, req_ready}, 32'd1);
      check("rst resp", {30'd0, resp_valid, resp_err}, 32'd0);
      check("rst rdata", resp_rdata, 32'd0);

      // Aligned word store then load
      do_req(1, 2'b10, 0, 32'h1010, 32'hDEAD_BEEF, lat, rd, er);
      check("st_w lat", lat, 2);
      check("st_w err", {31'd0, er}, 32'd0);
      check("st_w rdata", rd, 32'd0);
      check("st_w nbeats", 32'(beats.size()), 32'd1);
      check_beat("st_w b0", 0, 32'h1010, 4'hF, 32'hDEAD_BEEF, 0, 1);
      @(negedge clk);
      check("st_w pulse end", {31'd0, resp_valid}, 32'd0);

      do_req(0, 2'b10, 0, 32'h1010, 32'd0, lat, rd, er);
      check("ld_w lat", lat, 2);
      check("ld_w rdata", rd, 32'hDEAD_BEEF);
      check("ld_w err", {31'd0, er}, 32'd0);
      check_beat("ld_w b0", 0, 32'h1010, 4'hF, 32'd0, 1, 0);

      // Byte lanes
      do_req(1, 2'b00, 0, 32'h1013, 32'h0000_0080, lat, rd, er);
      check("st_b lat", lat, 2);
      check_beat("st_b b0", 0, 32'h1010, 4'h8, 32'h8000_0000, 0, 1);
      check("st_b mem", mem[10'h004], 32'h80AD_BEEF);
      do_req(0, 2'b00, 0, 32'h1013, 32'd0, lat, rd, er);
      check("ld_b signed", rd, 32'hFFFF_FF80);
      do_req(0, 2'b00, 1, 32'h1013, 32'd0, lat, rd, er);
      check("ld_b unsigned", rd, 32'h0000_0080);

      // Split half
      do_req(1, 2'b10, 0, 32'h1020, 32'h1122_3344, lat, rd, er);
      do_req(1, 2'b10, 0, 32'h1024, 32'h5566_7788, lat, rd, er);
      do_req(0, 2'b01, 0, 32'h1023, 32'd0, lat, rd, er);
      check("ld_h split lat", lat, 3);
      check("ld_h split signed", rd, 32'hFFFF_8811);
      check("ld_h nbeats", 32'(beats.size()), 32'd2);
      check_beat("ld_h b0", 0, 32'h1020, 4'h8, 32'd0, 1, 0);
      check_beat("ld_h b1", 1, 32'h1024, 4'h1, 32'd0, 1, 0);
      do_req(0, 2'b01, 1, 32'h1023, 32'd0, lat, rd, er);
      check("ld_h split unsigned", rd, 32'h0000_8811);

      do_req(1, 2'b01, 0, 32'h1023, 32'h0000_AABB, lat, rd, er);
      check("st_h split lat", lat, 3);
      check_beat("st_h b0", 0, 32'h1020, 4'h8, 32'hBB00_0000, 0, 1);
      check_beat("st_h b1", 1, 32'h1024, 4'h1, 32'h0000_00AA, 0, 1);
      check("st_h mem lo", mem[10'h008], 32'hBB22_3344);
      check("st_h mem hi", mem[10'h009], 32'h5566_77AA);

      do_req(0, 2'b10, 0, 32'h1022, 32'd0, lat, rd, er);
      check("ld_w split lat", lat, 3);
      check("ld_w split rdata", rd, 32'h77AA_BB22);
      check_beat("ld_w split b0", 0, 32'h1020, 4'hC, 32'd0, 1, 0);
      check_beat("ld_w split b1", 1, 32'h1024, 4'h3, 32'd0, 1, 0);

      // Errors: no bus activity, 1-cycle latency
      do_req(0, 2'b10, 0, 32'h1FFE, 32'd0, lat, rd, er);
      check("err end lat", lat, 1);
      check("err end flag", {31'd0, er}, 32'd1);
      check("err end rdata", rd, 32'd0);
      check("err end beats", 32'(beats.size()), 32'd0);
      do_req(0, 2'b11, 0, 32'h1000, 32'd0, lat, rd, er);
      check("err size lat", lat, 1);
      check("err size flag", {31'd0, er}, 32'd1);
      check("err size beats", 32'(beats.size()), 32'd0);
      do_req(0, 2'b00, 0, 32'h0FFF, 32'd0, lat, rd, er);
      check("err base lat", lat, 1);
      check("err base flag", {31'd0, er}, 32'd1);
      check("err base rdata", rd, 32'd0);
      check("err base beats", 32'(beats.size()), 32'd0);
      do_req(1, 2'b10, 0, 32'h1FFE, 32'hFFFF_FFFF, lat, rd, er);
      check("err store flag", {31'd0, er}, 32'd1);
      check("err store beats", 32'(beats.size()), 32'd0);

      // Last valid word
      do_req(1, 2'b10, 0, 32'h1FFC, 32'h1234_5678, lat, rd, er);
      check("top st err", {31'd0, er}, 32'd0);
      do_req(0, 2'b10, 0, 32'h1FFC, 32'd0, lat, rd, er);
      check("top ld lat", lat, 2);
      check("top ld rdata", rd, 32'h1234_5678);

      // Handshake: req_valid held high across two requests
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 32'h1010;
      @(negedge clk);
      check("hs beat0 ready", {31'd0, req_ready}, 32'd0);
      check("hs beat0 re", {31'd0, re}, 32'd1);
      @(negedge clk);
      check("hs resp ready", {31'd0, req_ready}, 32'd0);
      check("hs resp valid", {31'd0, resp_valid}, 32'd1);
      check("hs resp rdata", resp_rdata, 32'h80AD_BEEF);
      @(negedge clk);
      check("hs idle ready", {31'd0, req_ready}, 32'd1);
      check("hs idle valid", {31'd0, resp_valid}, 32'd0);
      check("hs idle re", {31'd0, re}, 32'd0);
      @(negedge clk);
      check("hs 2nd ready", {31'd0, req_ready}, 32'd0);
      check("hs 2nd re", {31'd0, re}, 32'd1);
      req_valid = 1'b0;
      @(negedge clk);
      check("hs 2nd valid", {31'd0, resp_valid}, 32'd1);
      check("hs 2nd rdata", resp_rdata, 32'h80AD_BEEF);
      @(negedge clk);
      check("hs back idle", {31'd0, req_ready}, 32'd1);

      // Reset during BEAT1 of a split store
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 32'h1032; req_wdata = 32'hCAFE_F00D;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("rs beat0 wstrb", {28'd0, wstrb}, 32'hC);
      check("rs beat0 wdata", wdata, 32'hF00D_0000);
      @(negedge clk);
      check("rs beat1 addr", addr, 32'h1034);
      check("rs beat1 wstrb", {28'd0, wstrb}, 32'h3);
      check("rs beat1 wdata", wdata, 32'h0000_CAFE);
      rst_n = 1'b0;
      #1;
      check("rs bus zero", addr | wdata, 32'd0);
      check("rs ctl zero", {26'd0, re, we, wstrb}, 32'd0);
      check("rs idle", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      stray = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (resp_valid) stray++;
      end
      check("rs no resp", stray, 0);
      check("rs mem lo", mem[10'h00C], 32'hF00D_0000);
      check("rs mem hi", mem[10'h00D], 32'h0000_0000);

      check("re&we never both", both_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
